lut_layer_sequencer: RTL and testbench

- Time-multiplexed evaluator for one LogicNets layer of FANIN-input, 1-bit-output truth-table neurons.
- Neurons share a single runtime-loadable truth-table memory. They are evaluated one per cycle, and the layer output is presented as a NEURONS-bit vector.
- Sits between upstream connectivity wiring, which presents each neuron's FANIN-bit slice, and the next layer or the readout classifier.
- Trades latency for area versus a fully parallel ROM layer; allows retraining without resynthesis.

---
 rtl/lut_layer_sequencer.sv | 146 ++++++++++++++
 tb/tb_lut_layer_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LogicNets layer: NEURONS truth-table neurons evaluated one per cycle
// from a shared runtime-loadable table. Define LUT_SEQ_PIPE_EN to register the table read.
module lut_layer_sequencer #(
    parameter int unsigned  NEURONS = 8,
    parameter int unsigned  FANIN   = 6,
    localparam int unsigned IDX_W   = $clog2(NEURONS)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_cfg_we,
    input  logic [IDX_W+FANIN-1:0]     i_cfg_addr,
    input  logic                       i_cfg_data,
    output logic                       o_cfg_err,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [NEURONS*FANIN-1:0]   i_in_vec,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [NEURONS-1:0]         o_out_vec,
    output logic                       o_busy
);

    localparam int unsigned      AW    = IDX_W + FANIN;
    localparam int unsigned      DEPTH = 1 << AW;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NEURONS - 1);

    typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

    state_e                     r_state, w_state_d;
    logic                       r_table [DEPTH];
    logic [NEURONS*FANIN-1:0]   r_vec;
    logic [NEURONS-1:0]         r_result;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_cfg_err;
    logic [FANIN-1:0]           w_slice;
    logic [AW-1:0]              w_rd_addr;
    logic                       w_rd_bit;
    logic                       w_accept;
    logic                       w_last;

    assign w_accept  = i_in_valid && (r_state == StIdle);
    assign w_slice   = r_vec[32'(r_idx) * FANIN +: FANIN];
    assign w_rd_addr = {r_idx, w_slice};
    assign w_rd_bit  = r_table[w_rd_addr];

    // Table is deliberately outside the reset domain so trained contents survive rst_n.
    always_ff @(posedge i_clk) begin
        if (i_cfg_we && (r_state == StIdle)) begin
            r_table[i_cfg_addr] <= i_cfg_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cfg_err <= 1'b0;
        end else if (i_cfg_we && (r_state != StIdle)) begin
            r_cfg_err <= 1'b1;
        end
    end

`ifdef LUT_SEQ_PIPE_EN
    logic             r_drain;
    logic             r_rd_vld;
    logic             r_rd_bit;
    logic [IDX_W-1:0] r_rd_idx;

    assign w_last = r_rd_vld && (r_rd_idx == LAST);

    // Issue stage reads idx 0..NEURONS-1; writeback trails by one cycle from r_rd_*.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vec    <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_drain  <= 1'b0;
            r_rd_vld <= 1'b0;
            r_rd_bit <= 1'b0;
            r_rd_idx <= '0;
        end else if (w_accept) begin
            r_vec    <= i_in_vec;
            r_result <= '0;
            r_idx    <= '0;
            r_drain  <= 1'b0;
            r_rd_vld <= 1'b0;
        end else begin
            if (r_rd_vld) begin
                r_result[r_rd_idx] <= r_rd_bit;
            end
            if ((r_state == StEval) && !r_drain) begin
                r_rd_bit <= w_rd_bit;
                r_rd_idx <= r_idx;
                r_rd_vld <= 1'b1;
                r_idx    <= (r_idx == LAST) ? '0 : r_idx + IDX_W'(1);
                r_drain  <= (r_idx == LAST);
            end else begin
                r_rd_vld <= 1'b0;
            end
        end
    end
`else
    assign w_last = (r_idx == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vec    <= '0;
            r_result <= '0;
            r_idx    <= '0;
        end else if (w_accept) begin
            r_vec    <= i_in_vec;
            r_result <= '0;
            r_idx    <= '0;
        end else if (r_state == StEval) begin
            r_result[r_idx] <= w_rd_bit;
            r_idx           <= (r_idx == LAST) ? '0 : r_idx + IDX_W'(1);
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept)    w_state_d = StEval;
            StEval:  if (w_last)      w_state_d = StDone;
            StDone:  if (i_out_ready) w_state_d = StIdle;
            default:                  w_state_d = StIdle;
        endcase
    end

    always_comb begin
        o_in_ready  = (r_state == StIdle);
        o_out_valid = (r_state == StDone);
        o_busy      = (r_state == StEval) || (r_state == StDone);
    end

    assign o_out_vec = r_result;
    assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Scoreboard bench for lut_layer_sequencer: a per-neuron truth-table model predicts each result;
// a negedge monitor pops and compares on every output handshake.
module tb_lut_layer_sequencer;

    localparam int N   = 8;
    localparam int F   = 6;
    localparam int IW  = $clog2(N);
    localparam int NI  = N * F;
`ifdef LUT_SEQ_PIPE_EN
    localparam int LAT = N + 1;
`else
    localparam int LAT = N;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [IW+F-1:0]   cfg_addr = '0;
    logic              cfg_data = 1'b0;
    logic              cfg_err;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NI-1:0]     in_vec = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [N-1:0]      out_vec;
    logic              busy;

    lut_layer_sequencer #(.NEURONS(N), .FANIN(F)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cfg_we    (cfg_we),
        .i_cfg_addr  (cfg_addr),
        .i_cfg_data  (cfg_data),
        .o_cfg_err   (cfg_err),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_vec    (in_vec),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_vec   (out_vec),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    bit           mdl [N][1 << F];
    logic [N-1:0] sb [$];
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        chkv(nm, 32'(act), 32'(exp));
    endtask

    function automatic logic [N-1:0] ref_eval(input logic [NI-1:0] v);
        logic [N-1:0] r;
        logic [F-1:0] s;
        for (int n = 0; n < N; n++) begin
            s    = v[n*F +: F];
            r[n] = mdl[n][s];
        end
        return r;
    endfunction

    // Monitor: every accepted result is checked against the oldest prediction.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chkv("sb_nonempty", 32'(0), 32'(1));
            end else begin
                logic [N-1:0] e;
                e = sb.pop_front();
                chkv("out_vec", 32'(out_vec), 32'(e));
            end
        end
    end

    task automatic cfg_write(input int n, input int e, input bit d);
        cfg_we   = 1'b1;
        cfg_addr = (IW+F)'((n << F) | e);
        cfg_data = d;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        mdl[n][e] = d;
    endtask

    task automatic send(input logic [NI-1:0] vec, input int hold, input bit scramble,
                        input bit inject, input bit cfg_hs, input bit rst_mid);
        logic [N-1:0] exp;
        logic [63:0]  rnd;
        logic [F-1:0] s5;
        int           c;
        bit           ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            chkv("in_ready_wait", 32'(0), 32'(1));
            return;
        end
        if (cfg_hs) begin
            // Write coinciding with the handshake must be visible to this evaluation.
            s5        = vec[5*F +: F];
            cfg_we    = 1'b1;
            cfg_addr  = (IW+F)'((5 << F) | int'(s5));
            cfg_data  = ~mdl[5][s5];
            mdl[5][s5] = ~mdl[5][s5];
        end
        exp = ref_eval(vec);
        if (!rst_mid) sb.push_back(exp);
        in_vec   = vec;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        chkb("busy_after_accept", busy, 1'b1);
        chkb("in_ready_after_accept", in_ready, 1'b0);
        ok = 1'b0;
        for (c = 1; c <= 60; c++) begin
            if (scramble) begin
                rnd    = {$urandom(), $urandom()};
                in_vec = rnd[NI-1:0];
            end
            if (inject && c == 2) begin
                cfg_we   = 1'b1;
                cfg_addr = (IW+F)'(1);
                cfg_data = 1'b1;
            end else begin
                cfg_we = 1'b0;
            end
            if (rst_mid && c == 5) begin
                rst_n = 1'b0;
                #1;
                chkb("rst_out_valid", out_valid, 1'b0);
                chkb("rst_in_ready", in_ready, 1'b1);
                chkb("rst_busy", busy, 1'b0);
                chkv("rst_out_vec", 32'(out_vec), 32'(0));
                chkb("rst_cfg_err", cfg_err, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        cfg_we = 1'b0;
        if (!ok) begin
            chkv("out_valid_timeout", 32'(0), 32'(1));
            return;
        end
        chkv("latency", 32'(c), 32'(LAT));
        for (int h = 0; h < hold; h++) begin
            chkb("hold_out_valid", out_valid, 1'b1);
            chkb("hold_in_ready", in_ready, 1'b0);
            chkv("hold_out_vec", 32'(out_vec), 32'(exp));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chkb("post_out_valid", out_valid, 1'b0);
        chkb("post_in_ready", in_ready, 1'b1);
        chkb("post_busy", busy, 1'b0);
    endtask

    initial begin
        logic [NI-1:0] v1, v2, vinj, vr;
        logic [63:0]   rnd;
        #12;
        chkb("reset_in_ready", in_ready, 1'b1);
        chkb("reset_out_valid", out_valid, 1'b0);
        chkb("reset_busy", busy, 1'b0);
        chkb("reset_cfg_err", cfg_err, 1'b0);
        chkv("reset_out_vec", 32'(out_vec), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < N; n++)
            for (int e = 0; e < (1 << F); e++)
                cfg_write(n, e, e == n);

        for (int n = 0; n < N; n++) begin
            v1[n*F +: F] = F'(n);
            v2[n*F +: F] = F'((n + 1) % N);
        end
        vinj        = v1;
        vinj[0 +: F] = F'(1);

        send(v1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(v2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        cfg_write(3, 4, 1'b1);
        send(v2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(v1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        chkb("cfg_err_idle", cfg_err, 1'b0);
        send(vinj, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        chkb("cfg_err_set", cfg_err, 1'b1);
        send(vinj, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(v1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(v1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(v1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(v2, 0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int t = 0; t < 30; t++) begin
            for (int w = 0; w < int'($urandom_range(0, 4)); w++)
                cfg_write(int'($urandom_range(0, N - 1)), int'($urandom_range(0, (1 << F) - 1)),
                          1'($urandom_range(0, 1)));
            rnd = {$urandom(), $urandom()};
            vr  = rnd[NI-1:0];
            send(vr, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chkv("sb_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
